// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port IDs and
// the legal range of the memory read latency.
package dmem_arbiter_pkg;

    typedef logic [1:0] state_t;
    typedef logic       port_id_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam port_id_t PORT_C = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, DMA port and memory-side signals around dmem_arbiter.
// Signal suffixes are from the arbiter's point of view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req_i;
    logic              c_we_i;
    logic [ADDR_W-1:0] c_addr_i;
    logic [DATA_W-1:0] c_wdata_i;
    logic              c_ack_o;
    logic [DATA_W-1:0] c_rdata_o;
    logic              c_stall_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
        output c_ack_o, c_rdata_o, c_stall_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_ack_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    // Requesters plus memory.
    modport master (
        output c_req_i, c_we_i, c_addr_i, c_wdata_i,
        input  c_ack_o, c_rdata_o, c_stall_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_ack_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way request picker: fixed priority to C, or round-robin against the
// last granted port when both request.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic i_c_req,
    input  logic i_d_req,
    input  logic i_rr_en,
    input  logic i_last_grant,
    output logic o_winner,
    output logic o_valid
);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        o_winner = PORT_C;
        o_valid  = i_c_req | i_d_req;
        if (i_c_req && i_d_req) begin
            o_winner = i_rr_en ? ~i_last_grant : PORT_C;
        end else if (i_d_req) begin
            o_winner = PORT_D;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM stage
// (port C) and a DMA/loader (port D); each access is IDLE->ISSUE->WAIT->DONE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter bit RR_EN   = 1'b1
) (
    input  logic          clk_i,
    input  logic          start_i,
    dmem_arbiter_if.slave bus,
    output logic          busy_o
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("dmem_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    port_id_t          r_owner;
    port_id_t          r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_winner;
    logic w_valid;
    logic w_issue;
    logic w_c_ack;
    logic w_d_ack;

    dmem_rr_pick u_pick (
        .i_c_req      (bus.c_req_i),
        .i_d_req      (bus.d_req_i),
        .i_rr_en      (RR_EN),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= PORT_C;
            r_last_grant <= PORT_D;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= (w_winner == PORT_D) ? bus.d_we_i    : bus.c_we_i;
                        r_addr       <= (w_winner == PORT_D) ? bus.d_addr_i  : bus.c_addr_i;
                        r_wdata      <= (w_winner == PORT_D) ? bus.d_wdata_i : bus.c_wdata_i;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= LAT_LOAD;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner == PORT_D) r_d_rdata <= bus.mem_rdata_i;
                        else                   r_c_rdata <= bus.mem_rdata_i;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_issue = (r_state == ST_ISSUE);
    assign w_c_ack = (r_state == ST_DONE) && (r_owner == PORT_C);
    assign w_d_ack = (r_state == ST_DONE) && (r_owner == PORT_D);

    assign bus.mem_en_o    = w_issue;
    assign bus.mem_we_o    = w_issue & r_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;

    assign bus.c_ack_o   = w_c_ack;
    assign bus.c_rdata_o = r_c_rdata;
    assign bus.c_stall_o = bus.c_req_i & ~w_c_ack;
    assign bus.d_ack_o   = w_d_ack;
    assign bus.d_rdata_o = r_d_rdata;

    assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances cover MEM_LAT=1 round-robin,
// MEM_LAT=1 fixed priority and MEM_LAT=4 round-robin.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_i;
    logic        busy_a, busy_b, busy_c;
    logic [15:0] cyc = 16'd0;
    int          n_vec = 0;
    int          n_err = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .RR_EN(1'b1)) dut_a (
        .clk_i(clk), .start_i(start_i), .bus(bus_a.slave), .busy_o(busy_a));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .RR_EN(1'b0)) dut_b (
        .clk_i(clk), .start_i(start_i), .bus(bus_b.slave), .busy_o(busy_b));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .RR_EN(1'b1)) dut_c (
        .clk_i(clk), .start_i(start_i), .bus(bus_c.slave), .busy_o(busy_c));

    // One-cycle-latency memory model behind dut_a.
    logic [31:0] mem_a [0:255];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (bus_a.mem_en_o) begin
            if (bus_a.mem_we_o) mem_a[bus_a.mem_addr_o[7:0]] <= bus_a.mem_wdata_o;
            else                rd_a <= mem_a[bus_a.mem_addr_o[7:0]];
        end
    end
    always @(posedge clk) cyc <= cyc + 16'd1;

    assign bus_a.mem_rdata_i = rd_a;
    assign bus_b.mem_rdata_i = 32'h0B0B_0B0B;
    assign bus_c.mem_rdata_i = {16'hC0DE, cyc};

    task automatic clear_inputs();
        bus_a.c_req_i = 0; bus_a.c_we_i = 0; bus_a.c_addr_i = '0; bus_a.c_wdata_i = '0;
        bus_a.d_req_i = 0; bus_a.d_we_i = 0; bus_a.d_addr_i = '0; bus_a.d_wdata_i = '0;
        bus_b.c_req_i = 0; bus_b.c_we_i = 0; bus_b.c_addr_i = '0; bus_b.c_wdata_i = '0;
        bus_b.d_req_i = 0; bus_b.d_we_i = 0; bus_b.d_addr_i = '0; bus_b.d_wdata_i = '0;
        bus_c.c_req_i = 0; bus_c.c_we_i = 0; bus_c.c_addr_i = '0; bus_c.c_wdata_i = '0;
        bus_c.d_req_i = 0; bus_c.d_we_i = 0; bus_c.d_addr_i = '0; bus_c.d_wdata_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        start_i = 1'b0;
        next_cycle();
        start_i = 1'b1;
    endtask

    // Runs one access on dut_a; lat is the ack cycle index (cycle 0 = request), -1 on timeout.
    task automatic access_a(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int lat, output int busy_n);
        bit got = 1'b0;
        lat = -1; busy_n = 0; rdata = '0;
        next_cycle();
        if (port == PORT_C) begin
            bus_a.c_req_i = 1; bus_a.c_we_i = we; bus_a.c_addr_i = addr; bus_a.c_wdata_i = wdata;
        end else begin
            bus_a.d_req_i = 1; bus_a.d_we_i = we; bus_a.d_addr_i = addr; bus_a.d_wdata_i = wdata;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (busy_a) busy_n++;
            if ((port == PORT_C) ? bus_a.c_ack_o : bus_a.d_ack_o) begin
                got   = 1'b1;
                lat   = k;
                rdata = (port == PORT_C) ? bus_a.c_rdata_o : bus_a.d_rdata_o;
            end
            next_cycle();
        end
        bus_a.c_req_i = 0;
        bus_a.d_req_i = 0;
    endtask

    task automatic test_reset();
        start_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b want 000", {busy_a, busy_b, busy_c}); end
        n_vec++; if ({bus_a.mem_en_o, bus_a.mem_we_o, bus_a.c_ack_o, bus_a.d_ack_o, bus_a.c_stall_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {bus_a.mem_en_o, bus_a.mem_we_o, bus_a.c_ack_o, bus_a.d_ack_o, bus_a.c_stall_o}); end
        n_vec++; if (bus_a.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus_a.mem_addr_o); end
        n_vec++; if ({bus_a.c_rdata_o, bus_a.d_rdata_o} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {bus_a.c_rdata_o, bus_a.d_rdata_o}); end
        next_cycle();
        start_i = 1'b1;
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        int lat, bn;
        access_a(PORT_D, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat, bn);
        next_cycle();
        bus_a.c_req_i = 1; bus_a.c_we_i = 0; bus_a.c_addr_i = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (bus_a.c_stall_o !== (k < 3)) begin n_err++; $display("FAIL rd_stall_c%0d: got %b want %b", k, bus_a.c_stall_o, (k < 3)); end
            n_vec++; if (bus_a.mem_en_o !== (k == 1)) begin n_err++; $display("FAIL rd_mem_en_c%0d: got %b want %b", k, bus_a.mem_en_o, (k == 1)); end
            n_vec++; if (bus_a.c_ack_o !== (k == 3)) begin n_err++; $display("FAIL rd_ack_c%0d: got %b want %b", k, bus_a.c_ack_o, (k == 3)); end
            if (k == 1) begin
                n_vec++; if ({bus_a.mem_we_o, bus_a.mem_addr_o} !== {1'b0, 32'h10}) begin
                    n_err++; $display("FAIL rd_issue: got we=%b addr=%h want we=0 addr=00000010", bus_a.mem_we_o, bus_a.mem_addr_o); end
            end
            if (k == 3) begin
                n_vec++; if (bus_a.c_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", bus_a.c_rdata_o); end
                n_vec++; if (bus_a.d_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_d_ack: got %b want 0", bus_a.d_ack_o); end
            end
            next_cycle();
        end
        bus_a.c_req_i = 0;
    endtask

    task automatic test_write_then_read();
        logic [31:0] rd;
        int lat, bn;
        access_a(PORT_D, 1'b1, 32'h20, 32'h1234_5678, rd, lat, bn);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_vec++; if (bn !== 3) begin n_err++; $display("FAIL wr_busy_cycles: got %0d want 3", bn); end
        n_vec++; if (mem_a[8'h20] !== 32'h1234_5678) begin n_err++; $display("FAIL wr_mem: got %h want 12345678", mem_a[8'h20]); end
        access_a(PORT_C, 1'b0, 32'h20, 32'h0, rd, lat, bn);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rb_latency: got %0d want 3", lat); end
        n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL rb_data: got %h want 12345678", rd); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last_k = -1;
        bit both = 1'b0;
        pulse_reset();
        next_cycle();
        bus_a.c_req_i = 1; bus_a.c_we_i = 0; bus_a.c_addr_i = 32'h10;
        bus_a.d_req_i = 1; bus_a.d_we_i = 0; bus_a.d_addr_i = 32'h20;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus_a.c_ack_o && bus_a.d_ack_o) both = 1'b1;
            if (bus_a.c_ack_o || bus_a.d_ack_o) begin
                n_vec++; if (bus_a.d_ack_o !== (n % 2 == 1)) begin n_err++; $display("FAIL rr_order_%0d: got d_ack=%b want %b", n, bus_a.d_ack_o, (n % 2 == 1)); end
                n_vec++; if ((bus_a.d_ack_o ? bus_a.d_rdata_o : bus_a.c_rdata_o) !== (bus_a.d_ack_o ? 32'h1234_5678 : 32'hDEAD_BEEF)) begin
                    n_err++; $display("FAIL rr_data_%0d: got c=%h d=%h", n, bus_a.c_rdata_o, bus_a.d_rdata_o); end
                n_vec++; if ((n == 0 ? k : k - last_k) !== (n == 0 ? 3 : 4)) begin
                    n_err++; $display("FAIL rr_spacing_%0d: got cycle %0d after %0d", n, k, last_k); end
                last_k = k;
                n++;
            end
            next_cycle();
        end
        bus_a.c_req_i = 0; bus_a.d_req_i = 0;
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL rr_grants: got %0d want 4", n); end
        n_vec++; if (both !== 1'b0) begin n_err++; $display("FAIL rr_dual_ack: got 1 want 0"); end
    endtask

    task automatic test_fixed_priority();
        int nc = 0, nd = 0, dk = -1;
        next_cycle();
        bus_b.c_req_i = 1; bus_b.c_addr_i = 32'h4;
        bus_b.d_req_i = 1; bus_b.d_addr_i = 32'h8;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus_b.c_ack_o) nc++;
            if (bus_b.d_ack_o) nd++;
            next_cycle();
        end
        n_vec++; if (nc !== 4) begin n_err++; $display("FAIL fp_c_grants: got %0d want 4", nc); end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL fp_d_grants: got %0d want 0", nd); end
        bus_b.c_req_i = 0;
        for (int k = 0; k < 10 && dk < 0; k++) begin
            @(negedge clk);
            if (bus_b.d_ack_o) dk = k;
            next_cycle();
        end
        bus_b.d_req_i = 0;
        n_vec++; if (dk !== 3) begin n_err++; $display("FAIL fp_d_after_c: got ack cycle %0d want 3", dk); end
    endtask

    task automatic test_latency4();
        logic [31:0] sample = '0;
        next_cycle();
        bus_c.c_req_i = 1; bus_c.c_we_i = 0; bus_c.c_addr_i = 32'h30;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_vec++; if ({bus_c.mem_en_o, bus_c.mem_addr_o} !== {1'b1, 32'h30}) begin
                    n_err++; $display("FAIL l4_issue: got en=%b addr=%h want en=1 addr=00000030", bus_c.mem_en_o, bus_c.mem_addr_o); end
            end
            if (k >= 2 && k <= 5) begin
                n_vec++; if ({busy_c, bus_c.c_ack_o, bus_c.mem_en_o} !== 3'b100) begin
                    n_err++; $display("FAIL l4_wait_c%0d: got busy/ack/en=%b want 100", k, {busy_c, bus_c.c_ack_o, bus_c.mem_en_o}); end
            end
            if (k == 5) sample = bus_c.mem_rdata_i;
            if (k == 6) begin
                n_vec++; if (bus_c.c_ack_o !== 1'b1) begin n_err++; $display("FAIL l4_ack_c6: got %b want 1", bus_c.c_ack_o); end
                n_vec++; if (bus_c.c_rdata_o !== sample) begin n_err++; $display("FAIL l4_data: got %h want %h", bus_c.c_rdata_o, sample); end
            end
            next_cycle();
        end
        bus_c.c_req_i = 0;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int first = -1;
        bit dgot = 1'b0;
        next_cycle();
        bus_c.c_req_i = 1; bus_c.c_we_i = 0; bus_c.c_addr_i = 32'h40;
        repeat (3) next_cycle();
        n_vec++; if (busy_c !== 1'b1) begin n_err++; $display("FAIL rm_busy_pre: got %b want 1", busy_c); end
        start_i = 1'b0;
        bus_c.c_req_i = 0;
        next_cycle();
        start_i = 1'b1;
        @(negedge clk);
        n_vec++; if ({busy_c, bus_c.c_ack_o, bus_c.mem_en_o, bus_c.mem_we_o, bus_c.c_stall_o} !== 5'b0) begin
            n_err++; $display("FAIL rm_ctrl: got %b want 00000", {busy_c, bus_c.c_ack_o, bus_c.mem_en_o, bus_c.mem_we_o, bus_c.c_stall_o}); end
        n_vec++; if ({bus_c.mem_addr_o, bus_c.c_rdata_o, bus_c.d_rdata_o} !== 96'h0) begin
            n_err++; $display("FAIL rm_data: got addr=%h c=%h d=%h want 0", bus_c.mem_addr_o, bus_c.c_rdata_o, bus_c.d_rdata_o); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_c.c_ack_o) acks++;
        end
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL rm_no_ack: got %0d acks want 0", acks); end
        next_cycle();
        bus_c.c_req_i = 1; bus_c.c_addr_i = 32'h44;
        bus_c.d_req_i = 1; bus_c.d_addr_i = 32'h48;
        for (int k = 0; k < 20 && first < 0; k++) begin
            @(negedge clk);
            if (bus_c.d_ack_o) first = PORT_D;
            else if (bus_c.c_ack_o) first = PORT_C;
            next_cycle();
        end
        bus_c.c_req_i = 0;
        n_vec++; if (first !== int'(PORT_C)) begin n_err++; $display("FAIL rm_tie_first: got port %0d want 0", first); end
        for (int k = 0; k < 20 && !dgot; k++) begin
            @(negedge clk);
            if (bus_c.d_ack_o) dgot = 1'b1;
            next_cycle();
        end
        bus_c.d_req_i = 0;
        n_vec++; if (dgot !== 1'b1) begin n_err++; $display("FAIL rm_tie_d: got no d_ack want one"); end
    endtask

    task automatic test_drop_mid();
        int acks = 0, issues = 0;
        next_cycle();
        bus_c.c_req_i = 1; bus_c.c_we_i = 0; bus_c.c_addr_i = 32'h50;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus_c.c_ack_o) acks++;
            if (bus_c.mem_en_o) issues++;
            if (k == 3) begin
                n_vec++; if (bus_c.c_stall_o !== 1'b0) begin n_err++; $display("FAIL dm_stall: got %b want 0", bus_c.c_stall_o); end
            end
            if (k == 6) begin
                n_vec++; if (bus_c.c_ack_o !== 1'b1) begin n_err++; $display("FAIL dm_ack_c6: got %b want 1", bus_c.c_ack_o); end
            end
            next_cycle();
            if (k == 1) bus_c.c_req_i = 0;
        end
        n_vec++; if (acks !== 1) begin n_err++; $display("FAIL dm_ack_count: got %0d want 1", acks); end
        n_vec++; if (issues !== 1) begin n_err++; $display("FAIL dm_issue_count: got %0d want 1", issues); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_round_robin();
        test_fixed_priority();
        test_latency4();
        test_reset_mid();
        test_drop_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
